// File: rtl/hv_fault_mgr.sv
// HV fault manager: debounced, masked, sticky error channels with first-fault
// capture and a NORMAL/WARN/SAFE/RECOVER reaction FSM driving PWM kill.
//
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_err_raw        raw error levels (ERR_NUM), synchronous to i_clk
//   i_err_mask       1 = channel ignored for sticky/first/FSM
//   i_err_kill       1 = PWM-kill class, 0 = report-only
//   i_flt_thr        debounce threshold (0 behaves as 1)
//   i_rec_time       recovery hold cycles
//   i_clr_vld/mask   W1C sticky clear
//   i_fsiso          external forced-safe (unmaskable kill)
//   o_err_flt        debounced levels
//   o_err_sticky     latched masked errors
//   o_first_vld/idx  first fault since last all-clear
//   o_pwm_kill       1 = PWM disabled
//   o_intb_n         active-low interrupt
//   o_fsm_st         0 NORMAL, 1 WARN, 2 SAFE, 3 RECOVER
module hv_fault_mgr #(
  parameter int ERR_NUM = 8,
  parameter int FLT_W   = 4,
  parameter int REC_W   = 8,
  parameter int IDX_W   = (ERR_NUM > 1) ? $clog2(ERR_NUM) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [ERR_NUM-1:0] i_err_raw,
  input  logic [ERR_NUM-1:0] i_err_mask,
  input  logic [ERR_NUM-1:0] i_err_kill,
  input  logic [FLT_W-1:0]   i_flt_thr,
  input  logic [REC_W-1:0]   i_rec_time,
  input  logic               i_clr_vld,
  input  logic [ERR_NUM-1:0] i_clr_mask,
  input  logic               i_fsiso,
  output logic [ERR_NUM-1:0] o_err_flt,
  output logic [ERR_NUM-1:0] o_err_sticky,
  output logic               o_first_vld,
  output logic [IDX_W-1:0]   o_first_idx,
  output logic               o_pwm_kill,
  output logic               o_intb_n,
  output logic [1:0]         o_fsm_st
);

  typedef enum logic [1:0] {
    ST_NORM = 2'd0,
    ST_WARN = 2'd1,
    ST_SAFE = 2'd2,
    ST_REC  = 2'd3
  } st_e;

  logic [ERR_NUM-1:0] r_flt;
  logic [FLT_W-1:0]   r_cnt [ERR_NUM];
  logic [ERR_NUM-1:0] r_sticky;
  logic               r_first_vld;
  logic [IDX_W-1:0]   r_first_idx;
  st_e                r_state;
  logic [REC_W-1:0]   r_rec_cnt;
  logic               r_pwm_kill;
  logic               r_intb_n;

  logic [FLT_W:0]     w_thr;
  logic [ERR_NUM-1:0] w_flt_nxt;
  logic [FLT_W-1:0]   w_cnt_nxt [ERR_NUM];
  logic [ERR_NUM-1:0] w_eff;
  logic               w_kill_act;
  logic               w_warn_act;
  logic [ERR_NUM-1:0] w_clr;
  logic [ERR_NUM-1:0] w_sticky_nxt;
  logic [IDX_W-1:0]   w_low_idx;
  logic               w_first_vld_nxt;
  logic [IDX_W-1:0]   w_first_idx_nxt;
  st_e                w_state_nxt;
  logic [REC_W-1:0]   w_rec_nxt;
  logic               w_pwm_kill_nxt;
  logic               w_intb_n_nxt;

  // one extra bit so cnt+1 never wraps in the compare
  assign w_thr = (i_flt_thr == '0) ? (FLT_W+1)'(1)
                                   : {1'b0, i_flt_thr};

  always_comb begin
    w_flt_nxt = r_flt;
    for (int i = 0; i < ERR_NUM; i++) begin
      w_cnt_nxt[i] = '0;
      if (i_err_raw[i] != r_flt[i]) begin
        if (({1'b0, r_cnt[i]} + (FLT_W+1)'(1)) >= w_thr)
          w_flt_nxt[i] = i_err_raw[i];
        else
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  assign w_eff      = r_flt & ~i_err_mask;
  assign w_kill_act = (|(w_eff & i_err_kill)) | i_fsiso;
  assign w_warn_act = |(w_eff & ~i_err_kill);

  // set wins over clear
  assign w_clr        = i_clr_mask & {ERR_NUM{i_clr_vld}};
  assign w_sticky_nxt = (r_sticky & ~w_clr) | w_eff;

  always_comb begin
    w_low_idx = '0;
    for (int i = ERR_NUM-1; i >= 0; i--)
      if (w_eff[i]) w_low_idx = IDX_W'(i);
  end

  // capture beats all-clear; idx retained on clear
  always_comb begin
    w_first_vld_nxt = r_first_vld;
    w_first_idx_nxt = r_first_idx;
    if (!r_first_vld && (w_eff != '0)) begin
      w_first_vld_nxt = 1'b1;
      w_first_idx_nxt = w_low_idx;
    end else if (w_sticky_nxt == '0) begin
      w_first_vld_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flt       <= '0;
      r_sticky    <= '0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
      for (int i = 0; i < ERR_NUM; i++)
        r_cnt[i] <= '0;
    end else begin
      r_flt       <= w_flt_nxt;
      r_sticky    <= w_sticky_nxt;
      r_first_vld <= w_first_vld_nxt;
      r_first_idx <= w_first_idx_nxt;
      for (int i = 0; i < ERR_NUM; i++)
        r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_REC;
      r_rec_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rec_cnt <= w_rec_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    w_rec_nxt   = r_rec_cnt;
    unique case (r_state)
      ST_NORM: begin
        if (w_kill_act)      w_state_nxt = ST_SAFE;
        else if (w_warn_act) w_state_nxt = ST_WARN;
      end
      ST_WARN: begin
        if (w_kill_act)       w_state_nxt = ST_SAFE;
        else if (!w_warn_act) w_state_nxt = ST_NORM;
      end
      ST_SAFE: begin
        if (!w_kill_act) begin
          w_state_nxt = ST_REC;
          w_rec_nxt   = '0;
        end
      end
      ST_REC: begin
        if (w_kill_act)
          w_state_nxt = ST_SAFE;
        else if (r_rec_cnt == i_rec_time)
          w_state_nxt = w_warn_act ? ST_WARN : ST_NORM;
        else
          w_rec_nxt = r_rec_cnt + 1'b1;
      end
    endcase
  end

  // FSM: outputs, from next state so they align with o_fsm_st
  always_comb begin
    w_pwm_kill_nxt = (w_state_nxt == ST_SAFE) |
                     (w_state_nxt == ST_REC);
    w_intb_n_nxt   = ~((w_state_nxt == ST_WARN) |
                       (w_state_nxt == ST_SAFE) |
                       (|w_sticky_nxt));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwm_kill <= 1'b1;
      r_intb_n   <= 1'b1;
    end else begin
      r_pwm_kill <= w_pwm_kill_nxt;
      r_intb_n   <= w_intb_n_nxt;
    end
  end

  assign o_err_flt    = r_flt;
  assign o_err_sticky = r_sticky;
  assign o_first_vld  = r_first_vld;
  assign o_first_idx  = r_first_idx;
  assign o_pwm_kill   = r_pwm_kill;
  assign o_intb_n     = r_intb_n;
  assign o_fsm_st     = r_state;

endmodule

// File: tb/tb_hv_fault_mgr.sv
// Bench for hv_fault_mgr: cycle model feeds an expected-output queue,
// plus directed scenario checks.
module tb_hv_fault_mgr;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] raw, mask, kill, clr_mask;
  logic [3:0] thr;
  logic [7:0] rec;
  logic       clr_vld, fsiso;

  logic [7:0] o_flt, o_sticky;
  logic       o_vld, o_kill, o_intb_n;
  logic [2:0] o_idx;
  logic [1:0] o_st;

  always #5 clk = ~clk;

  hv_fault_mgr #(
    .ERR_NUM(8), .FLT_W(4), .REC_W(8)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_err_raw(raw), .i_err_mask(mask),
    .i_err_kill(kill), .i_flt_thr(thr),
    .i_rec_time(rec), .i_clr_vld(clr_vld),
    .i_clr_mask(clr_mask), .i_fsiso(fsiso),
    .o_err_flt(o_flt), .o_err_sticky(o_sticky),
    .o_first_vld(o_vld), .o_first_idx(o_idx),
    .o_pwm_kill(o_kill), .o_intb_n(o_intb_n),
    .o_fsm_st(o_st)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model state
  logic [7:0] m_flt, m_sticky;
  int         m_cnt [8];
  logic       m_vld;
  int         m_idx, m_st, m_rec;
  logic [23:0] exp_q [$];

  function automatic logic [23:0] pk(
    input logic [7:0] f, input logic [7:0] s,
    input logic v, input logic [2:0] ix,
    input logic k, input logic ib,
    input logic [1:0] st);
    return {f, s, v, ix, k, ib, st};
  endfunction

  function automatic logic [23:0] obs();
    return pk(o_flt, o_sticky, o_vld, o_idx,
              o_kill, o_intb_n, o_st);
  endfunction

  task automatic mdl_reset();
    m_flt = 0; m_sticky = 0; m_vld = 0;
    m_idx = 0; m_st = 3; m_rec = 0;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
  endtask

  task automatic mdl_step();
    logic [7:0] eff, sn, nf;
    bit ka, wa;
    int ns, nr, te;
    logic k, ib;
    eff = m_flt & ~mask;
    ka  = (|(eff & kill)) || fsiso;
    wa  = |(eff & ~kill);
    sn  = (m_sticky & ~(clr_vld ? clr_mask : 8'h00)) | eff;
    ns  = m_st;
    nr  = m_rec;
    case (m_st)
      0, 1: ns = ka ? 2 : (wa ? 1 : 0);
      2: if (!ka) begin ns = 3; nr = 0; end
      default: begin
        if (ka) ns = 2;
        else if (m_rec == int'(rec)) ns = wa ? 1 : 0;
        else nr = (m_rec + 1) % 256;
      end
    endcase
    if (!m_vld && eff != 0) begin
      m_vld = 1;
      for (int i = 7; i >= 0; i--)
        if (eff[i]) m_idx = i;
    end else if (sn == 0) begin
      m_vld = 0;
    end
    te = (thr == 0) ? 1 : int'(thr);
    nf = m_flt;
    for (int i = 0; i < 8; i++) begin
      if (raw[i] == m_flt[i]) m_cnt[i] = 0;
      else if (m_cnt[i] + 1 >= te) begin
        nf[i] = raw[i];
        m_cnt[i] = 0;
      end else m_cnt[i]++;
    end
    m_flt = nf;
    m_sticky = sn;
    m_st = ns;
    m_rec = nr;
    k  = (ns == 2) || (ns == 3);
    ib = !((ns == 1) || (ns == 2) || (sn != 0));
    exp_q.push_back(pk(m_flt, m_sticky, m_vld,
                       3'(m_idx), k, ib, 2'(m_st)));
  endtask

  task automatic step();
    mdl_step();
    @(posedge clk);
    #1;
    chk("qdepth", exp_q.size(), 1);
    if (exp_q.size() > 0) chk("cyc", obs(), exp_q.pop_front());
  endtask

  task automatic clr_all();
    clr_vld = 1'b1;
    clr_mask = 8'hFF;
    step();
    clr_vld = 1'b0;
    clr_mask = 8'h00;
  endtask

  // steps until state differs from st; returns cycles spent in st
  task automatic dwell(input logic [1:0] st, output int n);
    n = 1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (o_st != st) return;
      n++;
    end
    chk("dwell_timeout", 32'(o_st), 32'(st) ^ 32'h1);
  endtask

  int n;

  initial begin
    raw = 0; mask = 0; kill = 0; thr = 1; rec = 3;
    clr_vld = 0; clr_mask = 0; fsiso = 0;
    mdl_reset();
    #12;
    chk("rst", obs(), pk(0, 0, 0, 0, 1, 1, 3));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: reset release recovery
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t1_kill", o_kill, 32'(k < 4));
    end
    chk("t1_st", o_st, 0);
    chk("t1_intb", o_intb_n, 1);

    // 2: debounce thr=4
    thr = 4; raw = 8'h04;
    repeat (3) step();
    raw = 8'h00;
    step();
    chk("t2_glitch", o_flt, 8'h00);
    raw = 8'h04;
    repeat (3) step();
    chk("t2_pre", o_flt, 8'h00);
    step();
    chk("t2_flt", o_flt, 8'h04);
    step();
    chk("t2_sticky", o_sticky, 8'h04);
    chk("t2_warn", o_st, 1);
    raw = 8'h00;
    repeat (4) step();
    clr_all();
    chk("t2_clr", o_sticky, 8'h00);

    // 3: kill channel 0
    thr = 1; kill = 8'h01; raw = 8'h01;
    step(); step();
    chk("t3_st", o_st, 2);
    chk("t3_kill", o_kill, 1);
    chk("t3_intb", o_intb_n, 0);
    raw = 8'h00;
    step(); step();
    chk("t3_rec", o_st, 3);
    dwell(2'd3, n);
    chk("t3_dwell", n, 32'(rec) + 1);
    chk("t3_norm", o_st, 0);
    chk("t3_pwm", o_kill, 0);
    clr_all();

    // 4: report ch5 + kill ch3 together
    kill = 8'h08; raw = 8'h28;
    step(); step();
    chk("t4_idx", o_idx, 3);
    chk("t4_vld", o_vld, 1);
    chk("t4_st", o_st, 2);

    // 5: W1C blocked while live, then full clear
    raw = 8'h20;
    step(); step();
    clr_all();
    chk("t5_hold", o_sticky, 8'h20);
    chk("t5_vld", o_vld, 1);
    raw = 8'h00;
    n = 0;
    while (o_st != 0 && n < 40) begin
      step();
      n++;
    end
    chk("t5_norm", o_st, 0);
    clr_all();
    chk("t5_sticky", o_sticky, 0);
    chk("t5_vld0", o_vld, 0);
    chk("t5_intb", o_intb_n, 1);

    // 6: fsiso during recovery restarts dwell
    rec = 5; fsiso = 1;
    step();
    fsiso = 0;
    step();
    chk("t6_rec", o_st, 3);
    step(); step();
    fsiso = 1;
    step();
    chk("t6_safe", o_st, 2);
    fsiso = 0;
    step();
    chk("t6_rec2", o_st, 3);
    dwell(2'd3, n);
    chk("t6_dwell", n, 6);

    // async reset mid-operation
    kill = 8'h01; raw = 8'h01; rec = 3;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("arst", obs(), pk(0, 0, 0, 0, 1, 1, 3));
    mdl_reset();
    exp_q.delete();
    raw = 0; kill = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // random traffic against the model
    rec = 2;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) raw = 8'($urandom);
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
      if ($urandom_range(0, 15) == 0) kill = 8'($urandom);
      if ($urandom_range(0, 31) == 0) thr = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) rec = 8'($urandom_range(0, 4));
      fsiso = ($urandom_range(0, 15) == 0);
      clr_vld = ($urandom_range(0, 7) == 0);
      clr_mask = 8'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
